// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART transmitter state encoding and default sizing.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_state_t;

  localparam int c_clks_per_bit = 868;
  localparam int c_data_width   = 8;

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_cnt
// Purpose  : Bit-period counter; bit_end marks the last clk of each bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_clks_per_bit
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  assign bit_end = (r_cnt == c_cnt_w'(CLKS_PER_BIT - 1));

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Pulls words from an upstream FIFO and sends them as 8N1 frames.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_clks_per_bit,
  parameter int DATA_WIDTH   = c_data_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int c_bit_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_t           r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_shreg, w_shreg_next;
  logic [c_bit_w-1:0]    r_bit_cnt, w_bit_cnt_next;
  logic                  r_tx, w_tx_next;
  logic                  w_bit_end;
  logic                  w_clr;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_clr),
    .bit_end(w_bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_shreg   <= w_shreg_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_tx      <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = r_shreg;
    w_bit_cnt_next = r_bit_cnt;
    fifo_rd        = 1'b0;
    w_tx_next      = 1'b1;

    case (r_state)
      IDLE: begin
        // Gate on rst so no read can leak out while the async reset holds IDLE.
        if (tx_en && !fifo_empty && !rst) begin
          fifo_rd      = 1'b1;
          w_state_next = FETCH;
        end
      end
      FETCH: begin
        w_shreg_next   = fifo_data;
        w_bit_cnt_next = '0;
        w_state_next   = START;
      end
      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shreg_next   = r_shreg >> 1;
          w_bit_cnt_next = r_bit_cnt + c_bit_w'(1);
          if (r_bit_cnt == c_bit_w'(DATA_WIDTH - 1)) begin
            w_state_next = STOP;
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // The line level is registered from the upcoming state so tx lines up
    // with the state it belongs to without a combinational output path.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shreg_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  assign w_clr      = (w_state_next != r_state);
  assign tx         = r_tx;
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == STOP) && w_bit_end;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Directed self-checking bench for fifo_uart_tx with a FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int CLKS_PER_BIT = 4;
  localparam int DATA_WIDTH   = 8;
  localparam int FRAME_LEN    = 42;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       frame_done;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_WIDTH  (DATA_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // 8-deep FIFO with one-cycle read latency
  logic [7:0] mem [8];
  logic [2:0] wr_ptr = '0;
  logic [2:0] rd_ptr = '0;
  logic [3:0] count = '0;
  logic       push_en = 1'b0;
  logic [7:0] push_d = 8'h00;
  logic       w_push, w_pop;

  assign w_push     = push_en && (count != 4'd8);
  assign w_pop      = fifo_rd && (count != 4'd0);
  assign fifo_empty = (count == 4'd0);

  always @(posedge clk) begin
    if (w_push) begin
      mem[wr_ptr] <= push_d;
      wr_ptr      <= wr_ptr + 3'd1;
    end
    if (w_pop) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 3'd1;
    end
    count <= count + 4'(w_push) - 4'(w_pop);
  end

  int cyc = 0;
  int rd_cnt = 0;
  int underflow = 0;
  int rd_busy = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) rd_cnt <= rd_cnt + 1;
    if (fifo_rd && fifo_empty) underflow <= underflow + 1;
    if (fifo_rd && busy) rd_busy <= rd_busy + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples: [0]=rd cycle, [1]=fetch, then 10 bits x 4 clks
  function automatic logic [FRAME_LEN-1:0] expand(input logic [9:0] b);
    logic [FRAME_LEN-1:0] r;
    r      = '0;
    r[1:0] = 2'b11;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < CLKS_PER_BIT; j++)
        r[2 + CLKS_PER_BIT*i + j] = b[i];
    return r;
  endfunction

  function automatic logic [9:0] fbits(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    push_en = 1'b1;
    push_d  = d;
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic capture(input string tag, input logic [FRAME_LEN-1:0] exp_tx,
                         input int drop_at, output int rd_cyc);
    logic [FRAME_LEN-1:0] tv, fv;
    int n;
    n = 0;
    while (!fifo_rd && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!fifo_rd) begin
      check({tag, "_rd_timeout"}, 64'd0, 64'd1);
      rd_cyc = -1;
    end else begin
      rd_cyc = cyc;
      for (int i = 0; i < FRAME_LEN; i++) begin
        if (i > 0) @(negedge clk);
        tv[i] = tx;
        fv[i] = frame_done;
        if (i == drop_at) tx_en = 1'b0;
      end
      check({tag, "_tx"}, 64'(tv), 64'(exp_tx));
      check({tag, "_done"}, 64'(fv), 64'(42'h1 << 41));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r0, r1, r2, r3, bad_rd, bad_tx, n;
    logic [7:0] s6 [8];
    s6 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    // Reset with a word pending and tx_en high: nothing may move
    push(8'hA5);
    tx_en = 1'b1;
    @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fifo_rd", 64'(fifo_rd), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);

    // Scenario 1: 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    r0 = rd_cnt;
    rst = 1'b0;
    #1;
    capture("s1", expand(10'h34A), -1, r1);
    repeat (5) @(negedge clk);
    check("s1_rd_count", 64'(rd_cnt - r0), 64'd1);
    check("s1_busy", 64'(busy), 64'd0);

    // Scenario 2: back-to-back frames with 2-cycle gap
    tx_en = 1'b0;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    tx_en = 1'b1;
    #1;
    capture("s2a", expand(fbits(8'h00)), -1, r1);
    capture("s2b", expand(fbits(8'hFF)), -1, r2);
    capture("s2c", expand(fbits(8'h3C)), -1, r3);
    check("s2_spacing_ab", 64'(r2 - r1), 64'd42);
    check("s2_spacing_bc", 64'(r3 - r2), 64'd42);
    repeat (3) @(negedge clk);
    check("s2_busy", 64'(busy), 64'd0);
    check("s2_tx_idle", 64'(tx), 64'd1);

    // Scenario 3: empty FIFO for 100 cycles
    bad_rd = 0;
    bad_tx = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_rd) bad_rd++;
      if (tx !== 1'b1) bad_tx++;
    end
    check("s3_no_rd", 64'(bad_rd), 64'd0);
    check("s3_tx_high", 64'(bad_tx), 64'd0);

    // Scenario 4: tx_en drops during 3rd data bit of 0x81
    tx_en = 1'b0;
    push(8'h81);
    push(8'h42);
    r0 = rd_cnt;
    tx_en = 1'b1;
    #1;
    capture("s4a", expand(fbits(8'h81)), 15, r1);
    repeat (20) @(negedge clk);
    check("s4_held_rd", 64'(rd_cnt - r0), 64'd1);
    check("s4_held_busy", 64'(busy), 64'd0);
    check("s4_held_pending", 64'(fifo_empty), 64'd0);
    tx_en = 1'b1;
    #1;
    capture("s4b", expand(fbits(8'h42)), -1, r2);

    // Scenario 5: reset during 5th data bit of 0xE5 (bit4 = 0)
    tx_en = 1'b0;
    push(8'hE5);
    push(8'h33);
    tx_en = 1'b1;
    #1;
    n = 0;
    while (!fifo_rd && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("s5_rd_seen", 64'(fifo_rd), 64'd1);
    repeat (23) @(negedge clk);
    check("s5_pre_rst_tx", 64'(tx), 64'd0);
    rst = 1'b1;
    #1;
    check("s5_rst_tx", 64'(tx), 64'd1);
    check("s5_rst_busy", 64'(busy), 64'd0);
    check("s5_rst_done", 64'(frame_done), 64'd0);
    @(negedge clk);
    check("s5_rst_no_rd", 64'(fifo_rd), 64'd0);
    rst = 1'b0;
    #1;
    capture("s5", expand(fbits(8'h33)), -1, r1);

    // Scenario 6: full FIFO drained in order
    tx_en = 1'b0;
    for (int k = 0; k < 8; k++) push(s6[k]);
    r0 = rd_cnt;
    tx_en = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      capture($sformatf("s6_%0d", k), expand(fbits(s6[k])), -1, r1);
    end
    repeat (10) @(negedge clk);
    check("s6_rd_count", 64'(rd_cnt - r0), 64'd8);
    check("s6_empty", 64'(fifo_empty), 64'd1);
    check("s6_busy", 64'(busy), 64'd0);
    check("underflow", 64'(underflow), 64'd0);
    check("rd_while_busy", 64'(rd_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
